// File: rtl/bpred_tracker.sv
// bpred_tracker: in-order tracker of in-flight branch predictions.
// Each fetched instruction is recorded with its predicted next PC. When execute
// resolves the oldest entry, the tracker trains the BTB and, if the prediction was
// wrong, redirects fetch and flushes everything younger.
module bpred_tracker #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_valid,
  input  logic [31:0]                fetch_pc,
  input  logic                       pred_valid,
  input  logic                       pred_taken,
  input  logic [31:0]                pred_target,
  output logic                       fetch_ready,
  input  logic                       resolve_valid,
  input  logic                       resolve_is_branch,
  input  logic                       resolve_taken,
  input  logic [31:0]                resolve_target,
  output logic                       redirect_valid,
  output logic [31:0]                redirect_pc,
  output logic                       update_en,
  output logic [31:0]                update_pc,
  output logic                       actual_taken,
  output logic [31:0]                update_target,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNTW-1:0]            branch_cnt,
  output logic [CNTW-1:0]            mispred_cnt,
  output logic                       resolve_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Entry storage; carries data only, validity is tracked by count/pointers.
  logic [31:0] pc_mem    [DEPTH];
  logic        pv_mem    [DEPTH];
  logic [31:0] pnext_mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic        push_p0;
  logic        pop_p0;
  logic        train_p0;
  logic        mispred_p0;
  logic [31:0] push_pnext_p0;
  logic [31:0] head_pc_p0;
  logic        head_pv_p0;
  logic [31:0] head_pnext_p0;
  logic [31:0] anext_p0;

  // Performance counters stick at all-ones instead of wrapping.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  assign fetch_ready = (count < FULL_CNT) && !redirect_valid;
  assign occupancy   = count;

  // Stage 0: push/pop decisions and the actual-vs-predicted comparison on the head.
  always_comb begin
    push_p0       = fetch_valid & fetch_ready;
    pop_p0        = resolve_valid & (count != '0);
    push_pnext_p0 = (pred_valid & pred_taken) ? pred_target : fetch_pc + 32'd4;
    head_pc_p0    = pc_mem[rd_ptr];
    head_pv_p0    = pv_mem[rd_ptr];
    head_pnext_p0 = pnext_mem[rd_ptr];
    anext_p0      = (resolve_is_branch & resolve_taken) ? resolve_target
                                                        : head_pc_p0 + 32'd4;
    mispred_p0    = pop_p0 & (anext_p0 != head_pnext_p0);
    train_p0      = pop_p0 & (resolve_is_branch | head_pv_p0);
  end

  // Write the new entry; a push alongside a mispredicting pop is wrong-path and dropped.
  always_ff @(posedge clk) begin
    if (push_p0 && !mispred_p0) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      pv_mem[wr_ptr]    <= pred_valid;
      pnext_mem[wr_ptr] <= push_pnext_p0;
    end
  end

  // Circular-buffer bookkeeping; a mispredict empties the buffer at the pop edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (mispred_p0) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push_p0) wr_ptr <= wr_ptr + PW'(1);
      if (pop_p0)  rd_ptr <= rd_ptr + PW'(1);
      if (push_p0 && !pop_p0)      count <= count + CW'(1);
      else if (pop_p0 && !push_p0) count <= count - CW'(1);
    end
  end

  // Stage 1: registered BTB update, redirect pulse, counters and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      update_en      <= 1'b0;
      update_pc      <= '0;
      actual_taken   <= 1'b0;
      update_target  <= '0;
      branch_cnt     <= '0;
      mispred_cnt    <= '0;
      resolve_err    <= 1'b0;
    end else begin
      redirect_valid <= mispred_p0;
      update_en      <= train_p0;
      if (mispred_p0) begin
        redirect_pc <= anext_p0;
        mispred_cnt <= sat_inc(mispred_cnt);
      end
      if (train_p0) begin
        update_pc     <= head_pc_p0;
        actual_taken  <= resolve_is_branch & resolve_taken;
        update_target <= resolve_target;
      end
      if (pop_p0 && resolve_is_branch) branch_cnt <= sat_inc(branch_cnt);
      if (resolve_valid && count == '0) resolve_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bpred_tracker.sv
// Scoreboard bench for bpred_tracker: directed stimulus queues the expected
// update/redirect events; a monitor compares them whenever the DUT emits one.
module tb_bpred_tracker;

  localparam int DEPTH = 4;
  localparam int CNTW  = 4;

  logic        clk;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        fetch_ready;
  logic        resolve_valid;
  logic        resolve_is_branch;
  logic        resolve_taken;
  logic [31:0] resolve_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        update_en;
  logic [31:0] update_pc;
  logic        actual_taken;
  logic [31:0] update_target;
  logic [$clog2(DEPTH):0] occupancy;
  logic [CNTW-1:0] branch_cnt;
  logic [CNTW-1:0] mispred_cnt;
  logic        resolve_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        upd;
    logic [31:0] upc;
    logic        act;
    logic [31:0] utgt;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  bpred_tracker #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .fetch_ready(fetch_ready),
    .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .update_en(update_en), .update_pc(update_pc), .actual_taken(actual_taken),
    .update_target(update_target), .occupancy(occupancy),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt), .resolve_err(resolve_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input logic upd, input logic [31:0] upc, input logic act,
                           input logic [31:0] utgt, input logic redir, input logic [31:0] rpc);
    exp_t e;
    e.upd = upd; e.upc = upc; e.act = act; e.utgt = utgt; e.redir = redir; e.rpc = rpc;
    sb.push_back(e);
  endtask

  task automatic drive(input logic fv, input logic [31:0] fpc, input logic pv, input logic pt,
                       input logic [31:0] ptgt, input logic rv, input logic rb,
                       input logic rtk, input logic [31:0] rtgt);
    fetch_valid = fv; fetch_pc = fpc; pred_valid = pv; pred_taken = pt; pred_target = ptgt;
    resolve_valid = rv; resolve_is_branch = rb; resolve_taken = rtk; resolve_target = rtgt;
    @(posedge clk);
    #1;
    fetch_valid = 0; fetch_pc = '0; pred_valid = 0; pred_taken = 0; pred_target = '0;
    resolve_valid = 0; resolve_is_branch = 0; resolve_taken = 0; resolve_target = '0;
  endtask

  task automatic push(input logic [31:0] pc, input logic pv, input logic pt, input logic [31:0] tgt);
    drive(1, pc, pv, pt, tgt, 0, 0, 0, '0);
  endtask

  task automatic resolve(input logic rb, input logic rtk, input logic [31:0] rtgt);
    drive(0, '0, 0, 0, '0, 1, rb, rtk, rtgt);
  endtask

  task automatic idle();
    drive(0, '0, 0, 0, '0, 0, 0, 0, '0);
  endtask

  // Monitor: every update/redirect pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && (update_en || redirect_valid)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event update_en=%b redirect_valid=%b update_pc=%h expected no event",
                 update_en, redirect_valid, update_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("update_en", {31'd0, update_en}, {31'd0, mon_e.upd});
        if (mon_e.upd) begin
          chk("update_pc", update_pc, mon_e.upc);
          chk("actual_taken", {31'd0, actual_taken}, {31'd0, mon_e.act});
          chk("update_target", update_target, mon_e.utgt);
        end
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, mon_e.redir});
        if (mon_e.redir) chk("redirect_pc", redirect_pc, mon_e.rpc);
      end
    end
  end

  initial begin
    fetch_valid = 0; fetch_pc = '0; pred_valid = 0; pred_taken = 0; pred_target = '0;
    resolve_valid = 0; resolve_is_branch = 0; resolve_taken = 0; resolve_target = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    chk("rst_update_en", {31'd0, update_en}, 32'd0);
    chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_branch_cnt", 32'(branch_cnt), 32'd0);
    chk("rst_resolve_err", {31'd0, resolve_err}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("post_rst_fetch_ready", {31'd0, fetch_ready}, 32'd1);
    idle();

    // Correct taken prediction
    push(32'h100, 1, 1, 32'h200);
    chk("s1_occ_after_push", 32'(occupancy), 32'd1);
    expect_ev(1, 32'h100, 1, 32'h200, 0, '0);
    resolve(1, 1, 32'h200);
    chk("s1_branch_cnt", 32'(branch_cnt), 32'd1);
    chk("s1_mispred_cnt", 32'(mispred_cnt), 32'd0);
    chk("s1_occ_after_pop", 32'(occupancy), 32'd0);
    idle();

    // Miss then taken: flush; push in mispredict cycle lost
    push(32'h100, 0, 0, '0);
    push(32'h104, 0, 0, '0);
    push(32'h108, 0, 0, '0);
    chk("s2_occ3", 32'(occupancy), 32'd3);
    expect_ev(1, 32'h100, 1, 32'h300, 1, 32'h300);
    drive(1, 32'h10C, 0, 0, '0, 1, 1, 1, 32'h300);
    chk("s2_occ_flushed", 32'(occupancy), 32'd0);
    chk("s2_ready_in_redirect", {31'd0, fetch_ready}, 32'd0);
    chk("s2_mispred_cnt", 32'(mispred_cnt), 32'd1);
    chk("s2_branch_cnt", 32'(branch_cnt), 32'd2);
    push(32'h999, 0, 0, '0);  // wrong-path fetch during redirect cycle
    chk("s2_no_push_in_redirect", 32'(occupancy), 32'd0);
    chk("s2_ready_after_redirect", {31'd0, fetch_ready}, 32'd1);

    // Full and wrap-around
    push(32'h400, 0, 0, '0);
    push(32'h404, 0, 0, '0);
    push(32'h408, 0, 0, '0);
    push(32'h40C, 0, 0, '0);
    chk("s3_occ_full", 32'(occupancy), 32'd4);
    chk("s3_ready_full", {31'd0, fetch_ready}, 32'd0);
    drive(1, 32'hBAD, 0, 0, '0, 1, 0, 0, '0);  // pop non-branch; same-cycle push refused
    chk("s3_occ_after_pop_full", 32'(occupancy), 32'd3);
    chk("s3_ready_after_pop", {31'd0, fetch_ready}, 32'd1);
    push(32'h500, 1, 1, 32'h600);
    chk("s3_occ_refill", 32'(occupancy), 32'd4);
    expect_ev(1, 32'h404, 0, 32'h0, 0, '0);
    resolve(1, 0, 32'h0);
    expect_ev(1, 32'h408, 0, 32'h0, 0, '0);
    resolve(1, 0, 32'h0);
    expect_ev(1, 32'h40C, 0, 32'h0, 0, '0);
    resolve(1, 0, 32'h0);
    expect_ev(1, 32'h500, 1, 32'h600, 0, '0);
    resolve(1, 1, 32'h600);
    chk("s3_branch_cnt", 32'(branch_cnt), 32'd6);
    chk("s3_mispred_cnt", 32'(mispred_cnt), 32'd1);
    chk("s3_occ_empty", 32'(occupancy), 32'd0);

    // PC wrap: 0xFFFFFFFC + 4 = 0, hit not-taken, resolve non-branch
    push(32'hFFFF_FFFC, 1, 0, 32'h1234);
    expect_ev(1, 32'hFFFF_FFFC, 0, 32'h55, 0, '0);
    resolve(0, 0, 32'h55);
    chk("wrap_mispred_cnt", 32'(mispred_cnt), 32'd1);
    idle();

    // BTB false hit on non-branch
    push(32'h40, 1, 1, 32'h80);
    expect_ev(1, 32'h40, 0, 32'h77, 1, 32'h44);
    resolve(0, 0, 32'h77);
    chk("s4_mispred_cnt", 32'(mispred_cnt), 32'd2);
    chk("s4_branch_cnt", 32'(branch_cnt), 32'd6);
    idle();

    // Empty resolve
    chk("s5_err_before", {31'd0, resolve_err}, 32'd0);
    resolve(1, 1, 32'hABC);
    chk("s5_err_set", {31'd0, resolve_err}, 32'd1);
    chk("s5_branch_cnt", 32'(branch_cnt), 32'd6);
    idle();
    idle();
    chk("s5_err_held", {31'd0, resolve_err}, 32'd1);

    // Back-to-back push/pop stream driving branch_cnt into saturation
    push(32'h1000, 1, 1, 32'h2000);
    for (int i = 1; i <= 10; i++) begin
      expect_ev(1, 32'h1000 + 32'(8 * (i - 1)), 1, 32'h2000, 0, '0);
      drive(1, 32'h1000 + 32'(8 * i), 1, 1, 32'h2000, 1, 1, 1, 32'h2000);
      if (i == 5) chk("s6_occ_steady", 32'(occupancy), 32'd1);
    end
    expect_ev(1, 32'h1050, 1, 32'h2000, 0, '0);
    resolve(1, 1, 32'h2000);
    chk("s6_branch_sat", 32'(branch_cnt), 32'd15);
    chk("s6_mispred_cnt", 32'(mispred_cnt), 32'd2);
    idle();
    chk("s6_sb_drained", 32'(sb.size()), 32'd0);

    // Reset mid-stream with a pulse pending
    push(32'h700, 1, 1, 32'h800);
    push(32'h704, 0, 0, '0);
    resolve(1, 0, 32'h0);
    #1 rst = 1'b0;
    #1;
    chk("s7_update_en", {31'd0, update_en}, 32'd0);
    chk("s7_redirect_valid", {31'd0, redirect_valid}, 32'd0);
    chk("s7_redirect_pc", redirect_pc, 32'd0);
    chk("s7_update_pc", update_pc, 32'd0);
    chk("s7_update_target", update_target, 32'd0);
    chk("s7_occupancy", 32'(occupancy), 32'd0);
    chk("s7_branch_cnt", 32'(branch_cnt), 32'd0);
    chk("s7_mispred_cnt", 32'(mispred_cnt), 32'd0);
    chk("s7_resolve_err", {31'd0, resolve_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("s7_ready_after_rst", {31'd0, fetch_ready}, 32'd1);
    push(32'h900, 1, 1, 32'h904);
    expect_ev(1, 32'h900, 0, 32'h11, 0, '0);
    resolve(0, 0, 32'h11);
    chk("s7_branch_cnt_post", 32'(branch_cnt), 32'd0);
    idle();
    chk("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpred_tracker.md
# bpred_tracker

In-order tracker for in-flight branch predictions, sitting between the fetch stage and the BTB update port. It accepts one entry per fetched instruction, holding PC, BTB prediction and predicted next PC. It retires entries in order as the execute stage resolves them. On retire it compares the predicted next PC with the actual next PC, then drives the BTB update port (`update_en`, `update_pc`, `actual_taken`, `update_target`) and a fetch redirect on misprediction.

## Interface
- `DEPTH`, 4: tracker entries; power of two, 2..16.
- `CNTW`, 16: width of the performance counters.

- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `fetch_valid`  in  1  fetch presents an instruction this cycle.
- `fetch_pc`  in  32  PC of that instruction.
- `pred_valid`  in  1  BTB hit for `fetch_pc`.
- `pred_taken`  in  1  BTB taken prediction.
- `pred_target`  in  32  BTB predicted target.
- `fetch_ready`  out  1  tracker can accept a push; combinational, equals count < `DEPTH` and `redirect_valid` low.
- `resolve_valid`  in  1  execute resolves the oldest entry.
- `resolve_is_branch`  in  1  resolved instruction is a control transfer.
- `resolve_taken`  in  1  actual direction.
- `resolve_target`  in  32  actual target.
- `redirect_valid`  out  1  registered one-cycle pulse: fetch must restart at `redirect_pc`.
- `redirect_pc`  out  32  registered correct next PC.
- `update_en`  out  1  registered one-cycle BTB write request.
- `update_pc`  out  32  PC being trained.
- `actual_taken`  out  1  outcome for the 2-bit counter.
- `update_target`  out  32  target to install.
- `occupancy`  out  $clog2(DEPTH)+1  live entry count.
- `branch_cnt`  out  `CNTW`  resolved branches; saturating.
- `mispred_cnt`  out  `CNTW`  mispredictions; saturating.
- `resolve_err`  out  1  sticky: a resolve arrived while empty.

## Operation
- **Storage.** Circular buffer with read pointer, write pointer and count. Pointers wrap modulo `DEPTH`.
- **Push.** A push occurs when `fetch_valid & fetch_ready`. The entry stores `fetch_pc`, `pred_valid`, `pred_taken` and `pnext`.
  - `pnext` = `pred_target` if `pred_valid & pred_taken`, else `fetch_pc+4`.
  - PC arithmetic is 32-bit modulo 2^32; `0xFFFFFFFC+4` = 0.
- **Pop.** A pop occurs when `resolve_valid` and count > 0. It always retires the oldest entry.
- **Actual next PC.** `anext` = `resolve_target` if `resolve_is_branch & resolve_taken`, else `pc+4`.
- **Misprediction.** A mispredict is `anext != pnext`. In the cycle after the pop:
  - `redirect_valid`=1 and `redirect_pc`=`anext`.
  - `mispred_cnt` increments.
  - At the same edge as the pop, every remaining entry is flushed: count=0 and both pointers are set equal.
  - A push in the same cycle as a mispredicting pop is discarded.
- **BTB training.** In the cycle after a pop with `resolve_is_branch | entry.pred_valid`:
  - `update_en`=1, `update_pc`=entry PC.
  - `actual_taken`=`resolve_is_branch & resolve_taken`.
  - `update_target`=`resolve_target`.
  - A non-branch that hit the BTB is therefore trained not-taken.
- **Branch count.** `branch_cnt` increments on each pop with `resolve_is_branch`.
- **Counter saturation.** Both counters hold at all-ones.
- **Simultaneous push/pop, non-mispredict.** Count is unchanged. The new entry is written at the write pointer while the old entry is read at the read pointer.
- **Full.** `fetch_ready`=0. A pop in that cycle frees a slot only from the next cycle; same-cycle push is not accepted.
- **Empty.** A resolve while empty is ignored: no pop, no update, no redirect, and `resolve_err` is set until reset.
- **Redirect cycle.** While `redirect_valid`=1, `fetch_ready`=0, so wrong-path fetches are never pushed.
- **Outputs hold.** Data outputs hold their last value when their valid is low.

## Timing
- **Reset values.** Reset clears count, pointers, `redirect_valid`, `redirect_pc`, `update_en`, `update_pc`, `actual_taken`, `update_target`, both counters and `resolve_err` to 0. `fetch_ready` reads 1 once reset deasserts.
- **Reset mid-operation.** All in-flight entries are dropped immediately, asynchronously. Pending outputs clear without completing.
- **Pop latency.** Pop to `update_en`/`redirect_valid`: 1 cycle. Both are single-cycle pulses.
- **Throughput.** One push and one pop per cycle.
- **Occupancy.** `occupancy` reflects state after the last edge; a push is visible the next cycle.
- **Minimum redirect spacing.** Two redirects are at least 2 cycles apart, because a redirect empties the tracker.

## Test plan
- **Correct taken prediction.** Push pc=0x100, BTB hit taken target 0x200. Resolve branch taken 0x200 -> next cycle: `update_en`=1, `update_pc`=0x100, `actual_taken`=1, `update_target`=0x200; `redirect_valid`=0; `branch_cnt`=1.
- **Miss, then taken: flush.** Push 0x100 (no BTB hit), then 0x104 and 0x108. Resolve 0x100 taken to 0x300 ->
  - next cycle: `redirect_valid`=1, `redirect_pc`=0x300, `update_en`=1, `mispred_cnt`=1;
  - `occupancy`=0 and `fetch_ready`=0 during the redirect cycle;
  - a push in the mispredict cycle is lost.
- **Full and wrap-around.** DEPTH=4: push 4 entries -> `fetch_ready`=0. Pop one -> ready=1 next cycle. Push 0x500 -> it lands in slot 0 after wrap and retires fifth in order.
- **BTB false hit.** Non-branch 0x40 with BTB hit taken to 0x80. Resolve `resolve_is_branch`=0 -> `redirect_pc`=0x44, `update_en`=1, `actual_taken`=0.
- **Empty resolve.** Resolve with occupancy 0 -> no `update_en`, no redirect, `resolve_err`=1 and held until `rst` low.
- **Saturation and reset.** Force `branch_cnt` to 0xFFFF, resolve another branch -> stays 0xFFFF. Assert `rst` low mid-stream -> all outputs 0 immediately.
